acard_port_bank: RTL and testbench

Parametrised successor to the Arcade Card mapper in the PCE CD subsystem. Provides `NPORTS` auto-indexing windows into external card RAM through a CPU MMIO register window. RAM is reached through a registered request/acknowledge handshake with CPU wait-state, replacing the zero-latency chip-select, so slow SDRAM/DDR backends can serve it. Adds a decrement mode, a configurable RAM address width, and an optional 32-bit shift/rotate unit.

---
 rtl/acard_pkg.sv | 61 ++++++
 rtl/acard_shifter.sv | 72 +++++++
 rtl/acard_port_bank.sv | 219 +++++++++++++++++++++
 tb/tb_acard_port_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acard_pkg.sv
// acard_pkg
// Shared types and constants for the Arcade Card port bank: per-port register
// set, control-bit positions, MMIO register offsets, FSM states and ID bytes.
// No ports (package only).
package acard_pkg;

  typedef struct packed {
    logic [23:0] base;
    logic [15:0] offset;
    logic [15:0] incr;
    logic [7:0]  ctrl;
  } port_t;

  // control register bit positions
  localparam int CTRL_STEP    = 0;
  localparam int CTRL_ADD     = 1;
  localparam int CTRL_SEXT    = 3;
  localparam int CTRL_TGT     = 4;
  localparam int CTRL_TRIG_LO = 5;
  localparam int CTRL_TRIG_HI = 6;
  localparam int CTRL_DEC     = 7;

  // per-port register offsets (A[3:0])
  localparam logic [3:0] REG_BASE0 = 4'd2;
  localparam logic [3:0] REG_BASE1 = 4'd3;
  localparam logic [3:0] REG_BASE2 = 4'd4;
  localparam logic [3:0] REG_OFS0  = 4'd5;
  localparam logic [3:0] REG_OFS1  = 4'd6;
  localparam logic [3:0] REG_INC0  = 4'd7;
  localparam logic [3:0] REG_INC1  = 4'd8;
  localparam logic [3:0] REG_CTRL  = 4'd9;
  localparam logic [3:0] REG_ADD   = 4'd10;

  // add-offset trigger encodings in ctrl[6:5]
  localparam logic [1:0] TRIG_OFS0 = 2'd1;
  localparam logic [1:0] TRIG_OFS1 = 2'd2;
  localparam logic [1:0] TRIG_ADD  = 2'd3;

  // global register offsets (A[4:0] with A[7:5] = 3'b111)
  localparam logic [4:0] GREG_SHIFT = 5'h04;
  localparam logic [4:0] GREG_ROT   = 5'h05;
  localparam logic [4:0] GREG_ID0   = 5'h1C;
  localparam logic [4:0] GREG_ID1   = 5'h1D;
  localparam logic [4:0] GREG_ID2   = 5'h1E;
  localparam logic [4:0] GREG_ID3   = 5'h1F;

  localparam logic [7:0] ID_BYTE0 = 8'h00;
  localparam logic [7:0] ID_BYTE1 = 8'h00;
  localparam logic [7:0] ID_BYTE2 = 8'h10;
  localparam logic [7:0] ID_BYTE3 = 8'h51;

  localparam logic [4:0] MMIO_PAGE_LO = 5'h1A;
  localparam logic [5:0] DIRECT_PAGE  = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/acard_shifter.sv
// acard_shifter
// 32-bit latch with byte load, shift and rotate, reachable through the global
// registers 0x00..0x05. Only compiled when ACARD_SHIFTER_EN is defined.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   wr         : one-cycle write strobe for global regs 0x00..0x05
//   sel        : A[2:0] register select
//   di         : CPU write data
//   rd         : read-back byte for the selected register
`ifdef ACARD_SHIFTER_EN
module acard_shifter
  import acard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [2:0] sel,
  input  logic [7:0] di,
  output logic [7:0] rd
);

  logic [31:0] latch;
  logic [3:0]  last_amt;
  logic [5:0]  amt;
  logic [31:0] shl, shr, rol, ror;

  // DI[3] selects right by 8-DI[2:0], giving a 1..8 right range
  assign amt = di[3] ? (6'd8 - {3'b000, di[2:0]}) : {3'b000, di[2:0]};
  assign shl = latch << amt;
  assign shr = latch >> amt;
  // shift by 32 (amt = 0) yields zero, so the rotate degenerates cleanly
  assign rol = shl | (latch >> (6'd32 - amt));
  assign ror = shr | (latch << (6'd32 - amt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch    <= '0;
      last_amt <= '0;
    end else if (wr) begin
      case (sel)
        3'd0: latch[7:0]   <= di;
        3'd1: latch[15:8]  <= di;
        3'd2: latch[23:16] <= di;
        3'd3: latch[31:24] <= di;
        GREG_SHIFT[2:0]: begin
          latch    <= di[3] ? shr : shl;
          last_amt <= di[3:0];
        end
        GREG_ROT[2:0]: begin
          latch    <= di[3] ? ror : rol;
          last_amt <= di[3:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = 8'hFF;
    case (sel)
      3'd0:            rd = latch[7:0];
      3'd1:            rd = latch[15:8];
      3'd2:            rd = latch[23:16];
      3'd3:            rd = latch[31:24];
      GREG_SHIFT[2:0]: rd = {4'h0, last_amt};
      GREG_ROT[2:0]:   rd = {4'h0, last_amt};
      default:         rd = 8'hFF;
    endcase
  end

endmodule
`endif

// File: rtl/acard_port_bank.sv
// acard_port_bank
// NPORTS auto-indexing windows into external card RAM, programmed through a
// CPU MMIO window. Data accesses go to RAM through a registered REQ/ACK
// handshake; the CPU is stalled via RDY while a request is outstanding.
// Optional feature macro: ACARD_SHIFTER_EN (32-bit shift/rotate unit).
// Ports:
//   CLK, RST_N        : clock, async active-low reset
//   EN                : card present
//   WR_N, RD_N, A, DI : CPU bus strobes, address, write data
//   DO                : CPU read data (0xFF when nothing selected)
//   SEL_N             : MMIO window select
//   RDY               : CPU ready (low = wait)
//   RAM_REQ/WE/A/D    : RAM request, write flag, address, write data
//   RAM_Q, RAM_ACK    : RAM read data, one-cycle completion
module acard_port_bank
  import acard_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int RAW    = 21
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic           WR_N,
  input  logic           RD_N,
  input  logic [20:0]    A,
  input  logic [7:0]     DI,
  output logic [7:0]     DO,
  output logic           SEL_N,
  output logic           RDY,
  output logic           RAM_REQ,
  output logic           RAM_WE,
  output logic [RAW-1:0] RAM_A,
  output logic [7:0]     RAM_D,
  input  logic [7:0]     RAM_Q,
  input  logic           RAM_ACK
);

  state_t         state, state_nxt;
  port_t          ports [4];
  port_t          sel_port, wr_next, cur;
  logic           acc, acc_q, acc_edge, idle;
  logic           mmio, direct, mmio_data, data_acc, port_ok;
  logic           start, reg_wr, port_wr, glob, step_en, trig;
  logic           ena;
  logic [1:0]     pidx, cur_idx;
  logic [RAW-1:0] addr;
  logic [7:0]     rdata;
  logic [7:0]     shf_rd;

  function automatic logic [RAW-1:0] ofs_ext(input logic [15:0] ofs, input logic sx);
    return {{(RAW-16){sx & ofs[15]}}, ofs};
  endfunction

  function automatic logic [23:0] base_add(input logic [23:0] b, input logic [15:0] ofs);
    return b + {{8{ofs[15]}}, ofs};
  endfunction

  function automatic port_t step_port(input port_t p);
    port_t r;
    r = p;
    if (p.ctrl[CTRL_TGT])
      r.base = p.ctrl[CTRL_DEC] ? p.base - {8'h00, p.incr} : p.base + {8'h00, p.incr};
    else
      r.offset = p.ctrl[CTRL_DEC] ? p.offset - p.incr : p.offset + p.incr;
    return r;
  endfunction

  // address decode
  assign acc       = ~(WR_N & RD_N);
  assign acc_edge  = acc & ~acc_q;
  assign idle      = (state == ST_IDLE);
  assign mmio      = EN & (&A[20:13]) & (A[12:8] == MMIO_PAGE_LO);
  assign SEL_N     = ~mmio;
  assign direct    = EN & ena & (A[20:15] == DIRECT_PAGE);
  assign mmio_data = mmio & ~A[7] & (A[3:1] == 3'b000);
  assign data_acc  = direct | mmio_data;
  assign pidx      = direct ? A[14:13] : A[5:4];
  assign port_ok   = ({1'b0, pidx} < 3'(NPORTS));
  assign start     = idle & acc_edge & data_acc & port_ok;
  assign reg_wr    = idle & acc_edge & ~WR_N & mmio & ~A[7];
  assign port_wr   = reg_wr & port_ok;
  assign glob      = mmio & (A[7:5] == 3'b111);

  assign sel_port  = ports[pidx];
  assign cur       = ports[cur_idx];
  assign step_en   = (state == ST_REQ) & RAM_ACK & cur.ctrl[CTRL_STEP];
  assign addr      = sel_port.base[RAW-1:0] +
                     (sel_port.ctrl[CTRL_ADD] ? ofs_ext(sel_port.offset, sel_port.ctrl[CTRL_SEXT])
                                              : '0);

  // register write image; the add-offset sees the offset including this byte
  always_comb begin
    wr_next = sel_port;
    trig    = 1'b0;
    case (A[3:0])
      REG_BASE0: wr_next.base[7:0]    = DI;
      REG_BASE1: wr_next.base[15:8]   = DI;
      REG_BASE2: wr_next.base[23:16]  = DI;
      REG_OFS0:  wr_next.offset[7:0]  = DI;
      REG_OFS1:  wr_next.offset[15:8] = DI;
      REG_INC0:  wr_next.incr[7:0]    = DI;
      REG_INC1:  wr_next.incr[15:8]   = DI;
      REG_CTRL:  wr_next.ctrl         = DI;
      default: ;
    endcase
    case (sel_port.ctrl[CTRL_TRIG_HI:CTRL_TRIG_LO])
      TRIG_OFS0: trig = (A[3:0] == REG_OFS0);
      TRIG_OFS1: trig = (A[3:0] == REG_OFS1);
      TRIG_ADD:  trig = (A[3:0] == REG_ADD);
      default:   trig = 1'b0;
    endcase
    if (trig) wr_next.base = base_add(wr_next.base, wr_next.offset);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) ports[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i < NPORTS) begin
          if (port_wr && pidx == 2'(i))
            ports[i] <= wr_next;
          else if (step_en && cur_idx == 2'(i))
            ports[i] <= step_port(cur);
        end
      end
    end
  end

  // request launch / completion capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q   <= 1'b0;
      ena     <= 1'b0;
      RAM_A   <= '0;
      RAM_WE  <= 1'b0;
      RAM_D   <= '0;
      cur_idx <= '0;
      rdata   <= '0;
    end else begin
      acc_q <= acc;
      if (reg_wr) ena <= 1'b1;
      if (start) begin
        RAM_A   <= addr;
        RAM_WE  <= ~WR_N;
        RAM_D   <= DI;
        cur_idx <= pidx;
      end
      if (state == ST_REQ && RAM_ACK && !RAM_WE) rdata <= RAM_Q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    RAM_REQ   = 1'b0;
    RDY       = 1'b1;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        RAM_REQ = 1'b1;
        RDY     = 1'b0;
        if (RAM_ACK) state_nxt = ST_HOLD;
      end
      ST_HOLD: if (!acc) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ACARD_SHIFTER_EN
  logic glob_wr;
  assign glob_wr = idle & acc_edge & ~WR_N & glob & (A[4:0] <= GREG_ROT);
  acard_shifter u_shifter (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr    (glob_wr),
    .sel   (A[2:0]),
    .di    (DI),
    .rd    (shf_rd)
  );
`else
  assign shf_rd = 8'hFF;
`endif

  always_comb begin
    DO = 8'hFF;
    if (data_acc) begin
      if (state == ST_HOLD && port_ok) DO = rdata;
    end else if (mmio && !A[7]) begin
      if (port_ok) begin
        case (A[3:0])
          REG_BASE0: DO = sel_port.base[7:0];
          REG_BASE1: DO = sel_port.base[15:8];
          REG_BASE2: DO = sel_port.base[23:16];
          REG_OFS0:  DO = sel_port.offset[7:0];
          REG_OFS1:  DO = sel_port.offset[15:8];
          REG_INC0:  DO = sel_port.incr[7:0];
          REG_INC1:  DO = sel_port.incr[15:8];
          REG_CTRL:  DO = sel_port.ctrl;
          default:   DO = 8'hFF;
        endcase
      end
    end else if (glob) begin
      case (A[4:0])
        GREG_ID0: DO = ID_BYTE0;
        GREG_ID1: DO = ID_BYTE1;
        GREG_ID2: DO = ID_BYTE2;
        GREG_ID3: DO = ID_BYTE3;
        default:  DO = (A[4:0] <= GREG_ROT) ? shf_rd : 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_acard_port_bank.sv
module tb_acard_port_bank;

  localparam int RAW = 21;

  logic           CLK = 1'b0;
  logic           RST_N, EN, WR_N, RD_N, RAM_ACK;
  logic [20:0]    A;
  logic [7:0]     DI, RAM_Q;
  logic [7:0]     DO, RAM_D;
  logic           SEL_N, RDY, RAM_REQ, RAM_WE;
  logic [RAW-1:0] RAM_A;

  int total = 0;
  int bad   = 0;

  acard_port_bank #(.NPORTS(2), .RAW(RAW)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .WR_N(WR_N), .RD_N(RD_N), .A(A), .DI(DI),
    .DO(DO), .SEL_N(SEL_N), .RDY(RDY), .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE),
    .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q), .RAM_ACK(RAM_ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [20:0] mreg(input logic [1:0] p, input logic [3:0] r);
    return {8'hFF, 5'h1A, 2'b00, p, r};
  endfunction

  function automatic logic [20:0] greg(input logic [4:0] r);
    return {8'hFF, 5'h1A, 3'b111, r};
  endfunction

  function automatic logic [20:0] dpage(input logic [1:0] p);
    return {6'h10, p, 13'h0000};
  endfunction

  task automatic wr_reg(input logic [20:0] addr, input logic [7:0] data);
    A = addr; DI = data; WR_N = 1'b0;
    tick();
    WR_N = 1'b1;
    tick();
  endtask

  task automatic rd_reg(input logic [20:0] addr, output logic [7:0] d);
    A = addr; RD_N = 1'b0;
    #1 d = DO;
    tick();
    RD_N = 1'b1;
    tick();
  endtask

  // strobe must already be asserted; returns in HOLD with strobe still asserted
  task automatic ram_access(input int ack_after, input logic [7:0] q,
                            output logic [RAW-1:0] a, output logic we,
                            output logic [7:0] d, output logic req, output int low);
    tick();
    a = RAM_A; we = RAM_WE; d = RAM_D; req = RAM_REQ;
    low = 0;
    for (int n = 0; n < 20; n++) begin
      if (RDY) break;
      low++;
      RAM_ACK = (n == ack_after);
      RAM_Q   = q;
      tick();
      RAM_ACK = 1'b0;
    end
  endtask

  logic [7:0]     rv;
  logic [RAW-1:0] a_s;
  logic           we_s, req_s;
  logic [7:0]     d_s;
  int             low;

  initial begin
    RST_N = 1'b0; EN = 1'b0; WR_N = 1'b1; RD_N = 1'b1; A = '0; DI = '0;
    RAM_Q = '0; RAM_ACK = 1'b0;
    #2;
    chk("rst_do", DO, 8'hFF);
    chk("rst_rdy", RDY, 1'b1);
    chk("rst_req", RAM_REQ, 1'b0);
    chk("rst_we", RAM_WE, 1'b0);
    chk("rst_ram_a", RAM_A, 21'h0);
    chk("rst_ram_d", RAM_D, 8'h00);
    tick(); tick();
    #3 RST_N = 1'b1;
    tick();
    EN = 1'b1;

    // port 0: base 0x012345, inc 2, ctrl 0x11, read via direct page 0x40
    wr_reg(mreg(0, 2), 8'h45);
    wr_reg(mreg(0, 3), 8'h23);
    wr_reg(mreg(0, 4), 8'h01);
    wr_reg(mreg(0, 7), 8'h02);
    wr_reg(mreg(0, 8), 8'h00);
    wr_reg(mreg(0, 9), 8'h11);
    rd_reg(mreg(0, 9), rv);
    chk("ctrl_readback", rv, 8'h11);
    A = dpage(0); RD_N = 1'b0;
    #1;
    chk("sel_n_direct", SEL_N, 1'b1);
    chk("t1_rdy_edge", RDY, 1'b1);
    ram_access(3, 8'hA5, a_s, we_s, d_s, req_s, low);
    chk("t1_req", req_s, 1'b1);
    chk("t1_ram_a", a_s, 21'h012345);
    chk("t1_we", we_s, 1'b0);
    chk("t1_rdy_low_cycles", low, 4);
    chk("t1_hold_do", DO, 8'hA5);
    chk("t1_hold_rdy", RDY, 1'b1);
    RD_N = 1'b1;
    tick();
    rd_reg(mreg(0, 2), rv);
    chk("t1_base0", rv, 8'h47);
    rd_reg(mreg(0, 3), rv);
    chk("t1_base1", rv, 8'h23);

    // port 1: ctrl 0x8B, offset 0xFFFE, base 0x10, inc 3, MMIO data write
    wr_reg(mreg(1, 2), 8'h10);
    wr_reg(mreg(1, 3), 8'h00);
    wr_reg(mreg(1, 4), 8'h00);
    wr_reg(mreg(1, 5), 8'hFE);
    wr_reg(mreg(1, 6), 8'hFF);
    wr_reg(mreg(1, 7), 8'h03);
    wr_reg(mreg(1, 8), 8'h00);
    wr_reg(mreg(1, 9), 8'h8B);
    A = mreg(1, 0); DI = 8'h5A; WR_N = 1'b0;
    #1;
    chk("sel_n_mmio", SEL_N, 1'b0);
    ram_access(0, 8'h00, a_s, we_s, d_s, req_s, low);
    chk("t2_ram_a", a_s, 21'h00000E);
    chk("t2_we", we_s, 1'b1);
    chk("t2_ram_d", d_s, 8'h5A);
    chk("t2_rdy_low_cycles", low, 1);
    WR_N = 1'b1;
    tick();
    rd_reg(mreg(1, 5), rv);
    chk("t2_ofs0", rv, 8'hFB);
    rd_reg(mreg(1, 6), rv);
    chk("t2_ofs1", rv, 8'hFF);
    rd_reg(mreg(1, 2), rv);
    chk("t2_base0", rv, 8'h10);

    // port 0: ctrl 0x60, offset 0x0100, add-trigger via reg 10
    wr_reg(mreg(0, 9), 8'h60);
    wr_reg(mreg(0, 5), 8'h00);
    wr_reg(mreg(0, 6), 8'h01);
    rd_reg(mreg(0, 3), rv);
    chk("t3_base1_pre", rv, 8'h23);
    A = mreg(0, 10); DI = 8'h00; WR_N = 1'b0;
    tick();
    chk("t3_no_req", RAM_REQ, 1'b0);
    WR_N = 1'b1;
    tick();
    rd_reg(mreg(0, 3), rv);
    chk("t3_base1", rv, 8'h24);
    rd_reg(mreg(0, 2), rv);
    chk("t3_base0", rv, 8'h47);
    rd_reg(mreg(0, 4), rv);
    chk("t3_base2", rv, 8'h01);

    // out-of-range port and global ID registers
    A = mreg(3, 0); RD_N = 1'b0;
    #1;
    chk("t4_port3_do", DO, 8'hFF);
    tick();
    chk("t4_port3_req", RAM_REQ, 1'b0);
    chk("t4_port3_rdy", RDY, 1'b1);
    RD_N = 1'b1;
    tick();
    rd_reg(greg(5'h1F), rv);
    chk("t4_id_1f", rv, 8'h51);
    rd_reg(greg(5'h1E), rv);
    chk("t4_id_1e", rv, 8'h10);

`ifdef ACARD_SHIFTER_EN
    wr_reg(greg(5'h00), 8'h01);
    wr_reg(greg(5'h01), 8'h00);
    wr_reg(greg(5'h02), 8'h00);
    wr_reg(greg(5'h03), 8'h80);
    wr_reg(greg(5'h05), 8'h01);
    rd_reg(greg(5'h00), rv);
    chk("sh_rol_b0", rv, 8'h03);
    rd_reg(greg(5'h03), rv);
    chk("sh_rol_b3", rv, 8'h00);
    rd_reg(greg(5'h05), rv);
    chk("sh_amt_rb", rv, 8'h01);
    wr_reg(greg(5'h05), 8'h0F);
    rd_reg(greg(5'h03), rv);
    chk("sh_ror_b3", rv, 8'h80);
    rd_reg(greg(5'h00), rv);
    chk("sh_ror_b0", rv, 8'h01);
`else
    rd_reg(greg(5'h04), rv);
    chk("noshf_04", rv, 8'hFF);
`endif

    // async reset while a request is outstanding
    wr_reg(mreg(0, 9), 8'h11);
    A = dpage(0); RD_N = 1'b0;
    tick();
    chk("t5_req_before", RAM_REQ, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_req_reset", RAM_REQ, 1'b0);
    chk("t5_rdy_reset", RDY, 1'b1);
    chk("t5_ram_a_reset", RAM_A, 21'h0);
    #2 RST_N = 1'b1; RD_N = 1'b1;
    tick(); tick();
    rd_reg(mreg(0, 2), rv);
    chk("t5_base0_after", rv, 8'h00);
    A = dpage(0); RD_N = 1'b0;
    tick();
    chk("t5_no_req_ena_clear", RAM_REQ, 1'b0);
    chk("t5_do_ena_clear", DO, 8'hFF);
    RD_N = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
